avalon_dram_controller_ctrl: RTL

- Control FSM for the Avalon DRAM controller datapath.
- Accepts NoC0 LOAD_MEM and STORE_MEM requests and sequences the datapath strobes (header capture, metadata, write source select, read capture, response header).
- Drives the Avalon-MM read/write handshake and the NoC0 val/rdy handshakes; the datapath does all address and data arithmetic.
- Sits between the NoC0 router port and the Avalon DRAM/EMIF interface, paired 1:1 with the datapath.

---
 rtl/avalon_dram_controller_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/avalon_dram_controller_ctrl.sv
// Control FSM for the Avalon DRAM controller: turns NoC0 LOAD_MEM/STORE_MEM requests into datapath strobes and Avalon-MM commands.
// Define AVALON_DRAM_CTRL_PERF_EN to build the load/store/stall performance counters; otherwise the perf ports read 0.
`ifndef MSG_TYPE_WIDTH
`define MSG_TYPE_WIDTH 8
`endif
`ifndef MSG_TYPE_LOAD_MEM
`define MSG_TYPE_LOAD_MEM 8'd19
`endif
`ifndef MSG_TYPE_STORE_MEM
`define MSG_TYPE_STORE_MEM 8'd20
`endif

module avalon_dram_controller_ctrl #(
    parameter logic [1:0] WR_DRAIN_SRC      = 2'd2,
    parameter logic [1:0] WR_FIRST_SRC      = 2'd1,
    parameter logic [1:0] WR_COPY_SRC       = 2'd0,
    parameter logic       METADATA_SEL_FULL = 1'd0,
    parameter logic       METADATA_SEL_PART = 1'd1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         noc0_ctovr_controller_val,
    output logic                         controller_noc0_ctovr_rdy,
    output logic                         controller_noc0_vrtoc_val,
    input  logic                         noc0_vrtoc_controller_rdy,
    output logic                         controller_mem_read,
    output logic                         controller_mem_write,
    input  logic                         mem_controller_wait_request,
    input  logic                         mem_controller_rd_data_valid,
    output logic                         ctrl_datap_store_hdr_flit,
    output logic                         ctrl_datap_init_metadata,
    output logic                         ctrl_datap_update_metadata,
    output logic                         ctrl_datap_update_metadata_sel,
    output logic                         ctrl_datap_send_hdr_flit,
    output logic                         ctrl_datap_incr_recv_flits,
    output logic                         ctrl_datap_incr_sent_flits,
    output logic                         ctrl_datap_store_rd_data,
    output logic                         ctrl_datap_store_save1,
    output logic                         ctrl_datap_store_msg_len,
    output logic [1:0]                   ctrl_datap_sel_store_src,
    input  logic [`MSG_TYPE_WIDTH-1:0]   datap_ctrl_msg_type,
    input  logic                         datap_ctrl_first_rd,
    input  logic                         datap_ctrl_last_req_flit,
    input  logic                         datap_ctrl_last_resp_flit,
    input  logic                         datap_ctrl_read_new_line,
    input  logic                         datap_ctrl_last_mem_write,
    output logic [31:0]                  perf_load_cnt,
    output logic [31:0]                  perf_store_cnt,
    output logic [31:0]                  perf_mem_stall_cnt
);

    localparam logic [`MSG_TYPE_WIDTH-1:0] LOAD_MEM  = `MSG_TYPE_LOAD_MEM;
    localparam logic [`MSG_TYPE_WIDTH-1:0] STORE_MEM = `MSG_TYPE_STORE_MEM;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST_FIRST,
        S_ST_BODY,
        S_ST_DRAIN,
        S_ST_ACK,
        S_LD_HDR,
        S_LD_REQ,
        S_LD_WAIT,
        S_LD_DATA,
        S_DISCARD
    } state_t;

    state_t state;
    state_t state_nxt;

    // The datapath tracks read position itself; the first-read flag is not needed here.
    logic unused_first_rd;
    assign unused_first_rd = datap_ctrl_first_rd;

    logic wr_done;
    assign wr_done = noc0_ctovr_controller_val & ~mem_controller_wait_request;

    always_comb begin
        state_nxt                      = state;
        controller_noc0_ctovr_rdy      = 1'b0;
        controller_noc0_vrtoc_val      = 1'b0;
        controller_mem_read            = 1'b0;
        controller_mem_write           = 1'b0;
        ctrl_datap_store_hdr_flit      = 1'b0;
        ctrl_datap_init_metadata       = 1'b0;
        ctrl_datap_update_metadata     = 1'b0;
        ctrl_datap_update_metadata_sel = METADATA_SEL_FULL;
        ctrl_datap_send_hdr_flit       = 1'b0;
        ctrl_datap_incr_recv_flits     = 1'b0;
        ctrl_datap_incr_sent_flits     = 1'b0;
        ctrl_datap_store_rd_data       = 1'b0;
        ctrl_datap_store_save1         = 1'b0;
        ctrl_datap_store_msg_len       = 1'b0;
        ctrl_datap_sel_store_src       = WR_COPY_SRC;

        case (state)
            S_IDLE: begin
                controller_noc0_ctovr_rdy = 1'b1;
                if (noc0_ctovr_controller_val) begin
                    ctrl_datap_store_hdr_flit = 1'b1;
                    ctrl_datap_init_metadata  = 1'b1;
                    ctrl_datap_store_msg_len  = 1'b1;
                    if (datap_ctrl_msg_type == STORE_MEM) begin
                        state_nxt = S_ST_FIRST;
                    end else if (datap_ctrl_msg_type == LOAD_MEM) begin
                        state_nxt = S_LD_HDR;
                    end else begin
                        state_nxt = S_DISCARD;
                    end
                end
            end
            // Each data flit becomes one write; the flit is only taken when the write lands.
            S_ST_FIRST, S_ST_BODY: begin
                ctrl_datap_sel_store_src  = (state == S_ST_FIRST) ? WR_FIRST_SRC : WR_COPY_SRC;
                controller_mem_write      = noc0_ctovr_controller_val;
                controller_noc0_ctovr_rdy = wr_done;
                if (wr_done) begin
                    ctrl_datap_store_save1         = 1'b1;
                    ctrl_datap_incr_recv_flits     = 1'b1;
                    ctrl_datap_update_metadata     = 1'b1;
                    ctrl_datap_update_metadata_sel = (state == S_ST_FIRST) ? METADATA_SEL_PART
                                                                            : METADATA_SEL_FULL;
                    if (datap_ctrl_last_mem_write) begin
                        state_nxt = S_ST_ACK;
                    end else if (datap_ctrl_last_req_flit) begin
                        state_nxt = S_ST_DRAIN;
                    end else begin
                        state_nxt = S_ST_BODY;
                    end
                end
            end
            S_ST_DRAIN: begin
                ctrl_datap_sel_store_src = WR_DRAIN_SRC;
                controller_mem_write     = 1'b1;
                if (!mem_controller_wait_request) begin
                    ctrl_datap_update_metadata = 1'b1;
                    state_nxt                  = S_ST_ACK;
                end
            end
            S_ST_ACK, S_LD_HDR: begin
                ctrl_datap_send_hdr_flit  = 1'b1;
                controller_noc0_vrtoc_val = 1'b1;
                if (noc0_vrtoc_controller_rdy) begin
                    state_nxt = (state == S_ST_ACK) ? S_IDLE : S_LD_REQ;
                end
            end
            S_LD_REQ: begin
                controller_mem_read = 1'b1;
                if (!mem_controller_wait_request) begin
                    state_nxt = S_LD_WAIT;
                end
            end
            S_LD_WAIT: begin
                if (mem_controller_rd_data_valid) begin
                    ctrl_datap_store_rd_data = 1'b1;
                    state_nxt                = S_LD_DATA;
                end
            end
            S_LD_DATA: begin
                controller_noc0_vrtoc_val = 1'b1;
                if (noc0_vrtoc_controller_rdy) begin
                    ctrl_datap_incr_sent_flits = 1'b1;
                    ctrl_datap_update_metadata = 1'b1;
                    if (datap_ctrl_last_resp_flit) begin
                        state_nxt = S_IDLE;
                    end else if (datap_ctrl_read_new_line) begin
                        state_nxt = S_LD_REQ;
                    end
                end
            end
            S_DISCARD: begin
                controller_noc0_ctovr_rdy = 1'b1;
                if (noc0_ctovr_controller_val) begin
                    ctrl_datap_incr_recv_flits = 1'b1;
                    if (datap_ctrl_last_req_flit) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Hold every handshake and strobe quiet while reset is asserted.
        if (rst) begin
            state_nxt                      = S_IDLE;
            controller_noc0_ctovr_rdy      = 1'b0;
            controller_noc0_vrtoc_val      = 1'b0;
            controller_mem_read            = 1'b0;
            controller_mem_write           = 1'b0;
            ctrl_datap_store_hdr_flit      = 1'b0;
            ctrl_datap_init_metadata       = 1'b0;
            ctrl_datap_update_metadata     = 1'b0;
            ctrl_datap_update_metadata_sel = METADATA_SEL_FULL;
            ctrl_datap_send_hdr_flit       = 1'b0;
            ctrl_datap_incr_recv_flits     = 1'b0;
            ctrl_datap_incr_sent_flits     = 1'b0;
            ctrl_datap_store_rd_data       = 1'b0;
            ctrl_datap_store_save1         = 1'b0;
            ctrl_datap_store_msg_len       = 1'b0;
            ctrl_datap_sel_store_src       = WR_COPY_SRC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef AVALON_DRAM_CTRL_PERF_EN
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;
    logic [31:0] stall_cnt;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == S_LD_HDR && noc0_vrtoc_controller_rdy) begin
                load_cnt <= load_cnt + 32'd1;
            end
            if (state == S_ST_ACK && noc0_vrtoc_controller_rdy) begin
                store_cnt <= store_cnt + 32'd1;
            end
            if ((controller_mem_read | controller_mem_write) & mem_controller_wait_request) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_load_cnt      = load_cnt;
    assign perf_store_cnt     = store_cnt;
    assign perf_mem_stall_cnt = stall_cnt;
`else
    assign perf_load_cnt      = '0;
    assign perf_store_cnt     = '0;
    assign perf_mem_stall_cnt = '0;
`endif

endmodule
